// File: rtl/sprite_pkg.sv
// Shared defaults and types for the sprite ROM arbiter.
package sprite_pkg;

  localparam int unsigned NREQ_DEFAULT      = 4;
  localparam int unsigned AW_DEFAULT        = 19;
  localparam int unsigned DW_DEFAULT        = 4;
  localparam int unsigned ROM_DEPTH_DEFAULT = 307200;
  localparam int unsigned ROM_LAT_DEFAULT   = 1;

  localparam int unsigned ID_W = $clog2(NREQ_DEFAULT);

  typedef logic [ID_W-1:0] req_id_t;

  // One in-flight read as it travels toward the response register.
  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    oob;
  } pipe_entry_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bus of the sprite ROM arbiter; slave is the arbiter side.
interface sprite_rom_arbiter_if
  import sprite_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT,
  parameter int unsigned AW   = AW_DEFAULT,
  parameter int unsigned DW   = DW_DEFAULT
);

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_address;
  logic [DW-1:0]      rom_q;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;

  // master plays both the requesters and the external ROM
  modport master (
    output req, addr, rom_q,
    input  gnt, rom_address, rsp_valid, rsp_data
  );

  modport slave (
    input  req, addr, rom_q,
    output gnt, rom_address, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin pick: first requester at or above ptr (modulo NREQ) wins.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            found
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      idx = IDW'((32'(ptr) + j) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one external palette ROM among NREQ requesters, one read per cycle,
// returning each word to its requester ROM_LAT+1 cycles after the grant.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEFAULT,
  parameter int unsigned AW        = AW_DEFAULT,
  parameter int unsigned DW        = DW_DEFAULT,
  parameter int unsigned ROM_DEPTH = ROM_DEPTH_DEFAULT,
  parameter int unsigned ROM_LAT   = ROM_LAT_DEFAULT
) (
  input logic                 vga_clk,
  input logic                 Reset,
  sprite_rom_arbiter_if.slave bus
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0] DEPTH_LIMIT = (AW+1)'(ROM_DEPTH);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_id;
  logic            pick_found;
  logic            accept;
  logic [AW-1:0]   acc_addr;
  logic            acc_oob;
  logic [IDW-1:0]  next_ptr;

  logic [AW-1:0]   rom_address;
  logic [NREQ-1:0] rsp_valid;
  logic [DW-1:0]   rsp_data;

  // Stage k holds the read accepted k+1 edges ago; the response register
  // after the last stage completes the ROM_LAT+1 deep pipeline.
  logic            pipe_valid [ROM_LAT];
  logic [IDW-1:0]  pipe_id    [ROM_LAT];
  logic            pipe_oob   [ROM_LAT];

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .id    (pick_id),
    .found (pick_found)
  );

  // Grant is combinational but suppressed while reset is held.
  always_comb begin
    accept   = pick_found && !Reset;
    bus.gnt  = accept ? pick_gnt : '0;
    acc_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) acc_addr = bus.addr[i*AW +: AW];
    end
    acc_oob  = {1'b0, acc_addr} >= DEPTH_LIMIT;
    next_ptr = (pick_id == IDW'(NREQ-1)) ? '0 : pick_id + IDW'(1);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      ptr         <= '0;
      rom_address <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      for (int unsigned k = 0; k < ROM_LAT; k++) begin
        pipe_valid[k] <= 1'b0;
        pipe_id[k]    <= '0;
        pipe_oob[k]   <= 1'b0;
      end
    end else begin
      if (accept) begin
        ptr         <= next_ptr;
        rom_address <= acc_addr;
      end
      pipe_valid[0] <= accept;
      pipe_id[0]    <= pick_id;
      pipe_oob[0]   <= acc_oob;
      for (int unsigned k = 1; k < ROM_LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_id[k]    <= pipe_id[k-1];
        pipe_oob[k]   <= pipe_oob[k-1];
      end
      // rom_q for the oldest stage is valid on this edge; out-of-range reads return 0
      rsp_valid <= pipe_valid[ROM_LAT-1] ? (NREQ'(1) << pipe_id[ROM_LAT-1]) : '0;
      if (pipe_valid[ROM_LAT-1]) begin
        rsp_data <= pipe_oob[ROM_LAT-1] ? '0 : bus.rom_q;
      end
    end
  end

  assign bus.rom_address = rom_address;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_data    = rsp_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized and directed bench for sprite_rom_arbiter against a queue-based model.
module tb_sprite_rom_arbiter;

  localparam int NREQ      = 4;
  localparam int AW        = 19;
  localparam int DW        = 4;
  localparam int ROM_DEPTH = 307200;
  localparam int ROM_LAT   = 1;

  logic vga_clk = 1'b0;
  logic Reset   = 1'b1;

  sprite_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  sprite_rom_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .ROM_DEPTH(ROM_DEPTH), .ROM_LAT(ROM_LAT)
  ) dut (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM contents: word = low bits of (address + 3), visible in the cycle after the address update
  assign bus.rom_q = DW'(bus.rom_address + AW'(3));

  typedef struct {
    int         due;
    int         id;
    logic [3:0] d;
  } pend_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_n = 0;
  int          m_ptr = 0;
  logic [18:0] m_rom = '0;
  logic [3:0]  m_rv = '0;
  logic [3:0]  m_rd = '0;
  pend_t       pq[$];

  function automatic logic [3:0] model_gnt();
    if (Reset) return 4'b0000;
    for (int j = 0; j < NREQ; j++) begin
      int i;
      i = (m_ptr + j) % NREQ;
      if (bus.req[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  task automatic drive(input logic [3:0] r, input int a0, input int a1, input int a2, input int a3);
    bus.req  = r;
    bus.addr = {19'(a3), 19'(a2), 19'(a1), 19'(a0)};
  endtask

  // Advance one clock edge and update the reference model with what was presented.
  task automatic tick();
    logic [3:0] g;
    int         k;
    int         a;
    logic       rst;
    pend_t      p;
    g   = model_gnt();
    rst = Reset;
    k   = 0;
    for (int i = 0; i < NREQ; i++) if (g[i]) k = i;
    a = int'(bus.addr[k*AW +: AW]);
    @(posedge vga_clk);
    edge_n++;
    if (rst) begin
      m_ptr = 0; m_rom = '0; m_rv = '0; m_rd = '0;
      pq.delete();
    end else begin
      m_rv = '0;
      if (pq.size() > 0 && pq[0].due == edge_n) begin
        m_rv = 4'(1 << pq[0].id);
        m_rd = pq[0].d;
        void'(pq.pop_front());
      end
      if (g != 4'b0000) begin
        p.due = edge_n + ROM_LAT;
        p.id  = k;
        p.d   = (a >= ROM_DEPTH) ? 4'd0 : 4'((a + 3) % 16);
        pq.push_back(p);
        m_ptr = (k + 1) % NREQ;
        m_rom = 19'(a);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(4'b1111, 1, 2, 3, 4);
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
    tick(); tick();
    n_cmp++;
    if ({bus.rom_address, bus.rsp_valid, bus.rsp_data} !== {19'd0, 4'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_regs got=%0d/%b/%0d want=0/0000/0", bus.rom_address, bus.rsp_valid, bus.rsp_data);
    end
    drive(4'b0000, 0, 0, 0, 0);
    Reset = 1'b0;
  endtask

  task automatic test_single();
    drive(4'b0001, 5, 0, 0, 0);
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt got=%b want=0001", bus.gnt); end
    tick();
    n_cmp++;
    if (bus.rom_address !== 19'd5) begin n_bad++; $display("FAIL single_addr got=%0d want=5", bus.rom_address); end
    drive(4'b0000, 5, 0, 0, 0);
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL idle_gnt got=%b want=0000", bus.gnt); end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data} !== {4'b0001, 4'd8}) begin
      n_bad++; $display("FAIL single_rsp got=%b/%0d want=0001/8", bus.rsp_valid, bus.rsp_data);
    end
    tick();
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data} !== {4'b0000, 4'd8}) begin
      n_bad++; $display("FAIL rsp_hold got=%b/%0d want=0000/8", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_round_robin();
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive(c < 8 ? 4'b1111 : 4'b0000, 7, 107, 207, 307);
      #1;
      n_cmp++;
      if (bus.gnt !== model_gnt() || (c < 8 && bus.gnt !== 4'(1 << (c % 4)))) begin
        n_bad++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, bus.gnt, model_gnt());
      end
      tick();
      n_cmp++;
      if ({bus.rom_address, bus.rsp_valid, bus.rsp_data} !== {m_rom, m_rv, m_rd}) begin
        n_bad++;
        $display("FAIL rr_rsp c=%0d got=%0d/%b/%0d want=%0d/%b/%0d", c, bus.rom_address, bus.rsp_valid,
                 bus.rsp_data, m_rom, m_rv, m_rd);
      end
    end
  endtask

  task automatic test_single_stream();
    for (int c = 0; c < 12; c++) begin
      drive(c < 10 ? 4'b0100 : 4'b0000, 0, 0, c, 0);
      #1;
      n_cmp++;
      if (bus.gnt !== (c < 10 ? 4'b0100 : 4'b0000)) begin
        n_bad++; $display("FAIL stream_gnt c=%0d got=%b", c, bus.gnt);
      end
      tick();
      if (c >= 1 && c <= 10) begin
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_data} !== {4'b0100, 4'((c + 2) % 16)}) begin
          n_bad++;
          $display("FAIL stream_rsp c=%0d got=%b/%0d want=0100/%0d", c, bus.rsp_valid, bus.rsp_data, (c + 2) % 16);
        end
      end
    end
  endtask

  task automatic test_oob();
    for (int c = 0; c < 4; c++) begin
      drive(c < 2 ? 4'b0010 : 4'b0000, 0, c == 0 ? 4 : ROM_DEPTH, 0, 0);
      #1;
      n_cmp++;
      if (bus.gnt !== (c < 2 ? 4'b0010 : 4'b0000)) begin n_bad++; $display("FAIL oob_gnt c=%0d got=%b", c, bus.gnt); end
      tick();
      if (c == 1 || c == 2) begin
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_data} !== {4'b0010, (c == 1) ? 4'd7 : 4'd0}) begin
          n_bad++; $display("FAIL oob_rsp c=%0d got=%b/%0d want=0010/%0d", c, bus.rsp_valid, bus.rsp_data, c == 1 ? 7 : 0);
        end
      end
    end
    n_cmp++;
    if (bus.rom_address !== 19'(ROM_DEPTH)) begin
      n_bad++; $display("FAIL oob_fwd got=%0d want=%0d", bus.rom_address, ROM_DEPTH);
    end
  endtask

  task automatic test_wrap();
    drive(4'b0100, 0, 0, 33, 0);
    #1; tick();
    drive(4'b1001, 40, 0, 0, 41);
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_gnt3 got=%b want=1000", bus.gnt); end
    tick();
    drive(4'b0001, 40, 0, 0, 41);
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_gnt0 got=%b want=0001", bus.gnt); end
    tick();
    drive(4'b0000, 0, 0, 0, 0);
    #1; tick(); tick();
  endtask

  task automatic test_reset_inflight();
    drive(4'b0011, 10, 11, 0, 0);
    #1; tick();
    drive(4'b0010, 10, 11, 0, 0);
    #1; tick();
    Reset = 1'b1;
    drive(4'b0000, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL inflight_gnt got=%b want=0000", bus.gnt); end
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (bus.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL inflight_rsp c=%0d got=%b want=0000", c, bus.rsp_valid); end
      tick();
    end
    drive(4'b0110, 0, 21, 22, 0);
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL post_reset_gnt got=%b want=0010", bus.gnt); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] r;
    int         a [4];
    logic [3:0] g;
    r = bus.req;
    for (int i = 0; i < 4; i++) a[i] = int'(bus.addr[i*AW +: AW]);
    for (int c = 0; c < 300; c++) begin
      drive(r, a[0], a[1], a[2], a[3]);
      #1;
      g = model_gnt();
      n_cmp++;
      if (bus.gnt !== g) begin n_bad++; $display("FAIL rand_gnt c=%0d got=%b want=%b", c, bus.gnt, g); end
      tick();
      n_cmp++;
      if ({bus.rom_address, bus.rsp_valid, bus.rsp_data} !== {m_rom, m_rv, m_rd}) begin
        n_bad++;
        $display("FAIL rand_rsp c=%0d got=%0d/%b/%0d want=%0d/%b/%0d", c, bus.rom_address, bus.rsp_valid,
                 bus.rsp_data, m_rom, m_rv, m_rd);
      end
      for (int i = 0; i < 4; i++) begin
        if (g[i] || !r[i]) begin
          r[i] = ($urandom_range(0, 2) != 0);
          a[i] = ($urandom_range(0, 7) == 0) ? ROM_DEPTH + int'($urandom_range(0, 1000))
                                             : int'($urandom_range(0, ROM_DEPTH - 1));
        end else if ($urandom_range(0, 15) == 0) begin
          r[i] = 1'b0;
        end
      end
    end
    drive(4'b0000, 0, 0, 0, 0);
  endtask

  initial begin
    drive(4'b0000, 0, 0, 0, 0);
    @(negedge vga_clk);
    test_reset();
    test_single();
    test_round_robin();
    test_single_stream();
    test_oob();
    test_wrap();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the run");
    $fatal(1, "timeout");
  end

endmodule
